r_channel: RTL
==============

R_CHANNEL -- requirements
Module: r_channel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning response data width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum accepted-but-unretired transactions (>=1).
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port a_accept, input, 1, A-channel handshake (obi req && internal_gnt) this cycle.
REQ-006 SHALL have port a_we, input, 1, write flag of the accepted request (1=write, 0=read).
REQ-007 SHALL have port ctrl_valid, input, 1, controller result valid.
REQ-008 SHALL have port ctrl_rdata, input, DATA_WIDTH, controller read data.
REQ-009 SHALL have port ctrl_err, input, 1, controller error flag.
REQ-010 SHALL have port ctrl_ready, output, 1, block accepts controller result this cycle.
REQ-011 SHALL have port rready, input, 1, master ready for R-channel response.
REQ-012 SHALL have port internal_gnt, output, 1, grant to A-channel capture stage.
REQ-013 SHALL have port rvalid, output, 1, OBI response valid.
REQ-014 SHALL have port rdata, output, DATA_WIDTH, OBI response data.
REQ-015 SHALL have port err, output, 1, OBI response error.
REQ-016 SHALL have port proto_err, output, 1, sticky flag: unsolicited controller result seen.

Function
REQ-017 SHALL keep outstanding counter, width $clog2(MAX_OUTSTANDING+1): +1 on a_accept, -1 on rvalid&&rready, unchanged on both.
REQ-018 SHALL drive internal_gnt = (outstanding < MAX_OUTSTANDING), from registered state only; no same-cycle bypass of a retiring response.
REQ-019 SHALL keep a we-order queue (depth MAX_OUTSTANDING): push a_we on a_accept, pop on controller-result push.
REQ-020 SHALL keep response FIFO (depth MAX_OUTSTANDING) of {rdata, err}; ctrl_ready = FIFO not full AND we-queue not empty.
REQ-021 SHALL push on ctrl_valid&&ctrl_ready; stored rdata = 0 when popped we bit is 1 (write), else ctrl_rdata; err = ctrl_err.
REQ-022 SHALL make a pushed result visible on rvalid/rdata/err exactly one cycle after the push edge (latency 1).
REQ-023 SHALL drive rvalid = FIFO not empty; rdata/err = FIFO head; hold all stable while rvalid&&!rready.
REQ-024 SHALL pop FIFO on rvalid&&rready; simultaneous push and pop when full SHALL NOT be allowed (ctrl_ready low when full).
REQ-025 SHALL drop ctrl_valid while we-queue empty, set proto_err=1 and leave it set until reset.
REQ-026 SHALL return responses strictly in acceptance order; pointers wrap modulo MAX_OUTSTANDING.
REQ-027 SHALL allow a_accept and push in the same cycle; we-queue SHALL pop the older entry.

Reset
REQ-028 SHALL on rst_n low asynchronously clear counter, both queues and proto_err.
REQ-029 SHALL drive during/after reset: rvalid=0, rdata=0, err=0, ctrl_ready=0, internal_gnt=1, proto_err=0.
REQ-030 SHALL discard all in-flight transactions on reset mid-operation; no response emitted afterwards.

Structure
REQ-031 SHALL place response-entry typedef {rdata, err} and OBI response struct in if_types_pkg.
REQ-032 SHALL instantiate one generic sub-module sync_fifo (parameters WIDTH, DEPTH; full/empty flags) for both queues.

Verification
REQ-033 Read: a_accept, a_we=0; ctrl_valid, rdata=0xDEAD_BEEF, rready=1 -> rvalid one cycle later, rdata=0xDEAD_BEEF, err=0, outstanding back to 0.
REQ-034 Write: a_we=1, ctrl_rdata=0x1234 -> rdata=0, err=ctrl_err.
REQ-035 Backpressure: 2 accepts, rready=0 -> internal_gnt=0 after 2nd; third result blocked, ctrl_ready=0; rready=1 -> in-order drain, gnt=1 after first retire.
REQ-036 Stall stability: rvalid, rready=0 for 5 cycles -> rdata/err unchanged each cycle.
REQ-037 Unsolicited ctrl_valid with no accept -> dropped, proto_err=1 sticky, rvalid stays 0.
REQ-038 Reset with 2 pending -> rvalid=0, internal_gnt=1 immediately; no late responses.

Source files
------------

// File: rtl/if_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_types_pkg
// Description : Shared OBI interface types: response FIFO entry and the
//               R-channel response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package if_types_pkg;

    // Widest response data the shared types carry. Blocks with a narrower
    // DATA_WIDTH leave the upper bits zero.
    localparam int OBI_DATA_W = 64;

    // One stored controller result, as queued for the R channel.
    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_entry_t;

    // R-channel response as presented to the OBI master.
    typedef struct packed {
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_rsp_t;

endpackage : if_types_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Generic single-clock FIFO with first-word fall-through head,
//               full/empty flags and modulo-DEPTH pointer wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers advance modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only honoured when a pop frees the slot
    // in the same cycle; reads of the head see the old value until the edge.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule : sync_fifo
`default_nettype wire

// File: rtl/r_channel.sv
`default_nettype none
// ============================================================================
// Module      : r_channel
// Description : OBI R-channel response path. Tracks accepted transactions,
//               matches controller results to the write/read flag of the
//               oldest pending request and returns responses in order.
// Revision    : 1.0 - initial release
// ============================================================================
module r_channel
    import if_types_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,   // must not exceed OBI_DATA_W
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_accept,
    input  logic                  a_we,
    input  logic                  ctrl_valid,
    input  logic [DATA_WIDTH-1:0] ctrl_rdata,
    input  logic                  ctrl_err,
    output logic                  ctrl_ready,
    input  logic                  rready,
    output logic                  internal_gnt,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  proto_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] outstanding;
    logic             retire;
    logic             res_push;
    logic             we_head;
    logic             we_full;
    logic             we_empty;
    logic             rsp_full;
    logic             rsp_empty;
    rsp_entry_t       push_entry;
    rsp_entry_t       head_entry;
    obi_rsp_t         rsp;

    assign retire = rsp.rvalid && rready;

    // Outstanding-transaction counter: accept adds, retire removes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({a_accept, retire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Grant comes from registered occupancy only; a response retiring this
    // cycle frees a slot for the next cycle, never the current one. The
    // order-queue term is redundant by construction but makes overflow of
    // that queue impossible by inspection.
    assign internal_gnt = (outstanding < CNT_W'(MAX_OUTSTANDING)) && !we_full;

    // A controller result is taken only when it has a pending request to
    // belong to and room in the response FIFO.
    assign ctrl_ready = !rsp_full && !we_empty;
    assign res_push   = ctrl_valid && ctrl_ready;

    // Build the stored entry: writes return zero data, reads return the
    // controller data; the error flag passes through either way.
    always_comb begin
        push_entry       = '0;
        push_entry.err   = ctrl_err;
        if (!we_head) begin
            push_entry.rdata = OBI_DATA_W'(ctrl_rdata);
        end
    end

    // Write-flag order queue: one entry per accepted, not-yet-answered request.
    sync_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_we_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (a_accept),
        .din   (a_we),
        .pop   (res_push),
        .dout  (we_head),
        .full  (we_full),
        .empty (we_empty)
    );

    // Response FIFO feeding the R channel.
    sync_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_push),
        .din   (push_entry),
        .pop   (retire),
        .dout  (head_entry),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    // Present the FIFO head; data/error are forced to zero when nothing is
    // valid so reset and idle outputs are clean.
    always_comb begin
        rsp        = '0;
        rsp.rvalid = !rsp_empty;
        if (!rsp_empty) begin
            rsp.rdata = head_entry.rdata;
            rsp.err   = head_entry.err;
        end
    end

    assign rvalid = rsp.rvalid;
    assign rdata  = rsp.rdata[DATA_WIDTH-1:0];
    assign err    = rsp.err;

    // Sticky protocol error: a controller result arrived with no request
    // waiting for it. The result itself is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (ctrl_valid && we_empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule : r_channel
`default_nettype wire
